// File: rtl/ahb_pkg.sv
// Shared types for the AHB-lite SRAM slave: transfer sizes, response
// codes, controller states and the byte-lane strobe helper.
package ahb_pkg;

  typedef enum logic [2:0] {
    HSIZE_BYTE     = 3'b000,
    HSIZE_HALFWORD = 3'b001,
    HSIZE_WORD     = 3'b010
  } hsize_t;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DATA,
    ST_ERR1,
    ST_ERR2
  } sram_state_e;

  // Only the address bits the size needs are looked at, so a misaligned
  // halfword still lands on haddr[1] and any word (or larger) is 4'b1111.
  function automatic logic [3:0] byte_strb(
    input logic [2:0] size,
    input logic [1:0] a
  );
    logic [3:0] s;
    case (size)
      HSIZE_BYTE:     s = 4'b0001 << a;
      HSIZE_HALFWORD: s = a[1] ? 4'b1100 : 4'b0011;
      default:        s = 4'b1111;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sram_bank.sv
// Word-organised SRAM: synchronous byte-masked write, asynchronous read.
// Ports: clk_i, we_i, be_i[3:0], addr_i (word index), wdata_i, rdata_o.
module sram_bank #(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [3:0]            be_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [31:0]           wdata_i,
  output logic [31:0]           rdata_o
);

  logic [31:0] mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 4; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-lite SRAM slave: address/data pipeline, wait states, byte lanes and
// a two-cycle ERROR response when AHB_SRAM_ERR_EN is defined.
// Ports: clk_i, reset_i (sync, active high), hsel_i, haddr_i, hwrite_i,
//   hsize_i, hwdata_i in; hrdata_o, hready_o, hresp_o out.
module ahb_sram_ctrl
  import ahb_pkg::*;
#(
  parameter int          DATA_WIDTH  = 32,
  parameter int          DEPTH_LOG2  = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  hsel_i,
  input  logic [DATA_WIDTH-1:0] haddr_i,
  input  logic                  hwrite_i,
  input  logic [2:0]            hsize_i,
  input  logic [DATA_WIDTH-1:0] hwdata_i,
  output logic [DATA_WIDTH-1:0] hrdata_o,
  output logic                  hready_o,
  output logic [1:0]            hresp_o
);

  localparam int AW = DEPTH_LOG2;

  sram_state_e   state_q, state_d;
  sram_state_e   start_st;
  logic [3:0]    cnt_q, cnt_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          write_q, write_d;
  logic [3:0]    strb_q, strb_d;

  logic [31:0] offset;
  logic [31:0] rdata;
  logic [1:0]  resp;
  logic        accept;
  logic        err;
  logic        we;

  assign offset = haddr_i - BASE_ADDR;
  assign accept = hsel_i & hready_o;

`ifdef AHB_SRAM_ERR_EN
  // A below-base address wraps to a huge offset, so one
  // high-bits test covers both ends of the window.
  assign err = (offset[31:AW+2] != '0)
             | ((hsize_i == HSIZE_HALFWORD) & haddr_i[0])
             | ((hsize_i == HSIZE_WORD) & (haddr_i[1:0] != 2'b00))
             | (hsize_i > HSIZE_WORD);
  assign hresp_o = resp;
  logic unused_bits;
  assign unused_bits = ^offset[1:0];
`else
  assign err = 1'b0;
  assign hresp_o = HRESP_OKAY;
  logic unused_bits;
  assign unused_bits = ^{offset[31:AW+2], offset[1:0], resp};
`endif

  assign start_st = err ? ST_ERR1
                  : (WAIT_STATES > 0) ? ST_WAIT : ST_DATA;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      write_q <= 1'b0;
      strb_q  <= '0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      write_q <= write_d;
      strb_q  <= strb_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    write_d = write_q;
    strb_d  = strb_q;
    unique case (state_q)
      ST_WAIT: begin
        if (cnt_q == 4'd0) state_d = ST_DATA;
        else cnt_d = cnt_q - 4'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = accept ? start_st : ST_IDLE;
    endcase
    if (accept) begin
      idx_d   = offset[AW+1:2];
      write_d = hwrite_i & ~err;
      strb_d  = byte_strb(hsize_i, haddr_i[1:0]);
      if (!err && WAIT_STATES > 0) begin
        cnt_d = 4'(WAIT_STATES - 1);
      end
    end
  end

  always_comb begin
    hready_o = 1'b1;
    resp     = HRESP_OKAY;
    hrdata_o = '0;
    unique case (state_q)
      ST_WAIT: hready_o = 1'b0;
      ST_DATA: hrdata_o = rdata;
      ST_ERR1: begin
        hready_o = 1'b0;
        resp     = HRESP_ERROR;
      end
      ST_ERR2: resp = HRESP_ERROR;
      default: ;
    endcase
  end

  // Reset on the final DATA edge abandons the write.
  assign we = (state_q == ST_DATA) & write_q & ~reset_i;

  sram_bank #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_bank (
    .clk_i  (clk_i),
    .we_i   (we),
    .be_i   (strb_q),
    .addr_i (idx_q),
    .wdata_i(hwdata_i),
    .rdata_o(rdata)
  );

endmodule
